// File: rtl/du_reg_way0.sv
// Way0 decode->execute skid register: two-entry FIFO (head H drives bundle_o, skid S behind it)
// with full flush and selective kill by path ID carried in the bundle's low two bits.
module du_reg_way0 #(
    parameter int XLEN      = 64,
    parameter int PAYLOAD_W = 5 + 1 + XLEN * 3 + 7 + 3 + 7 + 6 + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [PAYLOAD_W-1:0] bundle_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] bundle_o,
    input  logic                 ready_i,
    input  logic                 flush_i,
    input  logic                 kill_i,
    input  logic [1:0]           kill_pID_i,
    output logic [1:0]           count_o
);

    // state | meaning
    // EMPTY | no valid entries
    // ONE   | H valid, S unused
    // FULL  | H and S valid, S is the younger entry
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   h_q, h_d;
    logic [PAYLOAD_W-1:0]   s_q, s_d;
    logic                   push, pop;
    logic                   h_keep, s_keep, in_keep;
    logic [1:0]             n_keep;

    // Handshake outputs come straight from the state flops so ready_i never reaches ready_o.
    assign valid_o  = (state_q != EMPTY);
    assign ready_o  = (state_q != FULL);
    assign count_o  = state_q;
    assign bundle_o = h_q;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        h_keep  = (state_q != EMPTY) && !pop && (h_q[1:0] != kill_pID_i);
        s_keep  = (state_q == FULL) && (s_q[1:0] != kill_pID_i);
        in_keep = push && (bundle_i[1:0] != kill_pID_i);
        n_keep  = 2'(h_keep) + 2'(s_keep) + 2'(in_keep);

        if (flush_i) begin
            state_d = EMPTY;
        end else if (kill_i) begin
            // Survivors compact oldest-first into H then S; a popped head is already gone.
            if (h_keep) begin
                if (s_keep) begin
                    s_d = s_q;
                end else if (in_keep) begin
                    s_d = bundle_i;
                end
            end else if (s_keep) begin
                h_d = s_q;
                if (in_keep) begin
                    s_d = bundle_i;
                end
            end else if (in_keep) begin
                h_d = bundle_i;
            end
            case (n_keep)
                2'd0:    state_d = EMPTY;
                2'd1:    state_d = ONE;
                default: state_d = FULL;
            endcase
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        h_d     = bundle_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        h_d = bundle_i;
                    end else if (push) begin
                        s_d     = bundle_i;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        h_d     = s_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            h_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: tb/tb_du_reg_way0.sv
// Bench for du_reg_way0: directed scenarios plus random traffic, checked against a queue model
// of the buffer contents (FIFO order, flush clears, kill filters by pID).
module tb_du_reg_way0;

    localparam int XLEN = 64;
    localparam int PW   = 5 + 1 + XLEN * 3 + 7 + 3 + 7 + 6 + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [PW-1:0] bundle_i;
    logic          ready_o;
    logic          valid_o;
    logic [PW-1:0] bundle_o;
    logic          ready_i;
    logic          flush_i;
    logic          kill_i;
    logic [1:0]    kill_pID_i;
    logic [1:0]    count_o;

    du_reg_way0 #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .bundle_i   (bundle_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .bundle_o   (bundle_o),
        .ready_i    (ready_i),
        .flush_i    (flush_i),
        .kill_i     (kill_i),
        .kill_pID_i (kill_pID_i),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: expected contents of the buffer, oldest first.
    logic [PW-1:0] sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic          mon_en = 1'b0;

    // Transaction committed at the next edge, folded into the model one edge later.
    logic          p_push  = 1'b0;
    logic [PW-1:0] p_data  = '0;
    logic          p_flush = 1'b0;
    logic          p_kill  = 1'b0;
    logic [1:0]    p_kpid  = 2'd0;

    task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_bundle(input logic [1:0] pid);
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) b[i] = 1'($urandom_range(0, 1));
        b[1:0] = pid;
        return b;
    endfunction

    // Monitor: mid-cycle, compare DUT view against the model and retire the head on a handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", PW'(count_o), PW'(sb.size()));
            chk("valid", PW'(valid_o), PW'(sb.size() != 0));
            chk("ready", PW'(ready_o), PW'(sb.size() < 2));
            if (sb.size() != 0) begin
                chk("bundle", bundle_o, sb[0]);
                if (ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic apply_pending();
        logic [PW-1:0] keep[$];
        if (p_flush) begin
            sb.delete();
        end else begin
            if (p_push) sb.push_back(p_data);
            if (p_kill) begin
                keep = {};
                foreach (sb[i]) if (sb[i][1:0] != p_kpid) keep.push_back(sb[i]);
                sb = keep;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] pid, input logic rdy,
                         input logic fl, input logic kl, input logic [1:0] kp);
        @(posedge clk);
        #1;
        apply_pending();
        valid_i    = v;
        bundle_i   = rand_bundle(pid);
        ready_i    = rdy;
        flush_i    = fl;
        kill_i     = kl;
        kill_pID_i = kp;
        p_push  = v && (sb.size() < 2);
        p_data  = bundle_i;
        p_flush = fl;
        p_kill  = kl;
        p_kpid  = kp;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, rdy, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        rst        = 1'b0;
        valid_i    = 1'b0;
        bundle_i   = '0;
        ready_i    = 1'b0;
        flush_i    = 1'b0;
        kill_i     = 1'b0;
        kill_pID_i = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",  PW'(valid_o), '0);
        chk("rst_ready",  PW'(ready_o), PW'(1));
        chk("rst_count",  PW'(count_o), '0);
        chk("rst_bundle", bundle_o, '0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Streaming pIDs 0..3 with EX always ready
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 1'b1, 1'b0, 1'b0, 2'd0);
        idle(1'b1, 2);

        // Backpressure: A, B held, then drained in order
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        idle(1'b0, 1);
        idle(1'b1, 3);

        // Flush while full with a same-cycle push
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0);
        idle(1'b1, 2);

        // Kill head pID1, skid pID2 survives
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
        idle(1'b0, 2);
        idle(1'b1, 2);

        // Kill with simultaneous push, matching and not matching
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 2'd2);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd2);
        idle(1'b0, 1);
        idle(1'b1, 2);

        // Pop and kill of the head on the same cycle
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1);
        idle(1'b1, 2);

        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
        end
        idle(1'b1, 4);
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
